// File: rtl/spike_window_counter.sv
// spike_window_counter
// Turns the neuron core's 1-bit output spike into a spike rate: rising edges
// are counted over windows of WINDOW_LEN enabled cycles, and each window's
// count plus a burst flag is queued in a small FIFO. The FIFO is drained by
// the readout logic over a valid/ready handshake.
module spike_window_counter #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 5,
    parameter int BURST_TH   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    input  logic             enable,
    input  logic             clear,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_burst,
    output logic [7:0]       drop_cnt,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int PH_W  = $clog2(WINDOW_LEN);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    // Window / edge-detect state
    logic             spike_q, spike_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] acc_q, acc_d;

    // FIFO bookkeeping
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       drop_q, drop_d;

    // Combinational helpers
    logic             rise;
    logic [CNT_W:0]   sum_ext;
    logic [CNT_W-1:0] sum_sat;
    logic             close;
    logic             result_burst;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    // Per-entry views of the FIFO storage, used to select the head
    logic [CNT_W-1:0] entry_cnt   [FIFO_DEPTH];
    logic             entry_burst [FIFO_DEPTH];

    // Edge detect, saturating accumulate and window phase advance
    always_comb begin
        spike_d      = spike_in;
        rise         = spike_in & ~spike_q;
        sum_ext      = {1'b0, acc_q} + {{CNT_W{1'b0}}, rise};
        sum_sat      = sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];
        result_burst = (int'(sum_sat) >= BURST_TH);
        phase_d      = phase_q;
        acc_d        = acc_q;
        close        = 1'b0;
        if (clear) begin
            // Restart wins over everything; the partial window is discarded.
            phase_d = '0;
            acc_d   = '0;
        end else if (enable) begin
            if (phase_q == PHASE_LAST) begin
                close   = 1'b1;
                phase_d = '0;
                acc_d   = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
                acc_d   = sum_sat;
            end
        end
    end

    // FIFO push/pop/drop decisions and pointer/level updates
    always_comb begin
        fifo_full = (level_q == LVL_FULL);
        pop       = (level_q != '0) & out_ready;
        // A pop on the close cycle frees the slot the new result needs.
        push      = close & (~fifo_full | pop);
        drop      = close & fifo_full & ~pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        drop_d    = drop_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Window and FIFO control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q  <= 1'b0;
            phase_q  <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            spike_q  <= spike_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage: one register pair per entry, written when the write
    // pointer selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             burst_q, burst_d;

        // Capture the closing window's result into this slot
        always_comb begin
            cnt_d   = cnt_q;
            burst_d = burst_q;
            if (push && wr_ptr_q == PTR_W'(gi)) begin
                cnt_d   = sum_sat;
                burst_d = result_burst;
            end
        end

        // Entry registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                burst_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                burst_q <= burst_d;
            end
        end

        assign entry_cnt[gi]   = cnt_q;
        assign entry_burst[gi] = burst_q;
    end

    // Outputs come only from registers; an empty FIFO reads as zero.
    always_comb begin
        out_valid  = (level_q != '0);
        out_count  = out_valid ? entry_cnt[rd_ptr_q] : '0;
        out_burst  = out_valid ? entry_burst[rd_ptr_q] : 1'b0;
        drop_cnt   = drop_q;
        fifo_level = level_q;
    end

endmodule
